// File: rtl/tx_framer_pkg.sv
// Shared link-layer symbol constants and framer state encoding,
// reused by the TX framer and the RX deframer.
package tx_framer_pkg;

   localparam logic [8:0] SYM_K28_5 = 9'h1BC;
   localparam logic [8:0] SYM_D5_6  = 9'h0C5;
   localparam logic [8:0] SYM_SOP   = 9'h1FB;
   localparam logic [8:0] SYM_EOP   = 9'h1FD;
   localparam logic [8:0] SYM_ABORT = 9'h1FE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOP,
      ST_DATA,
      ST_DROP,
      ST_EOP
   } state_t;

endpackage

// File: rtl/tx_framer.sv
// Transmit framer: byte stream in, one 9-bit {k,byte} symbol per clock out,
// with idle ordered sets, SOP/EOP delimiters and abort on underrun.
module tx_framer
   import tx_framer_pkg::*;
#(
   parameter int IDLE_MIN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [8:0] sym_out,
   output logic       underrun,
   output logic       busy
);

   localparam logic [8:0] IDLE_MIN_C = IDLE_MIN[8:0];

   state_t     state_q, state_d;
   logic [8:0] sym_q, sym_d;
   logic       phase_q, phase_d;
   logic [7:0] gap_q, gap_d;
   logic       underrun_q, underrun_d;
   logic       busy_q, busy_d;

   logic [8:0] idle_sym;
   logic [7:0] gap_inc;
   logic       gap_ok;

   assign idle_sym = phase_q ? SYM_D5_6 : SYM_K28_5;
   assign gap_inc  = (gap_q == IDLE_MIN_C[7:0]) ? gap_q : gap_q + 8'd1;
   assign gap_ok   = ({1'b0, gap_q} + 9'd1) >= IDLE_MIN_C;

   always_comb begin
      state_d    = state_q;
      sym_d      = sym_q;
      phase_d    = phase_q;
      gap_d      = gap_q;
      underrun_d = 1'b0;
      busy_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            sym_d   = idle_sym;
            phase_d = ~phase_q;
            // Frames start only on the edge closing an idle pair.
            if (phase_q) begin
               gap_d = gap_inc;
               if (s_valid && gap_ok) begin
                  state_d = ST_SOP;
               end
            end
         end
         ST_SOP: begin
            sym_d   = SYM_SOP;
            busy_d  = 1'b1;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            busy_d = 1'b1;
            if (!s_valid) begin
               sym_d      = SYM_ABORT;
               underrun_d = 1'b1;
               gap_d      = 8'd0;
               phase_d    = 1'b0;
               state_d    = ST_DROP;
            end else begin
               sym_d = {1'b0, s_data};
               if (s_last) begin
                  state_d = ST_EOP;
               end
            end
         end
         ST_DROP: begin
            sym_d   = idle_sym;
            phase_d = ~phase_q;
            if (phase_q) begin
               gap_d = gap_inc;
            end
            if (s_valid && s_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_EOP: begin
            sym_d   = SYM_EOP;
            busy_d  = 1'b1;
            phase_d = 1'b0;
            gap_d   = 8'd0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sym_q      <= SYM_K28_5;
         phase_q    <= 1'b1;
         gap_q      <= 8'd0;
         underrun_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sym_q      <= sym_d;
         phase_q    <= phase_d;
         gap_q      <= gap_d;
         underrun_q <= underrun_d;
         busy_q     <= busy_d;
      end
   end

   assign s_ready  = (state_q == ST_DATA) || (state_q == ST_DROP);
   assign sym_out  = sym_q;
   assign underrun = underrun_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_tx_framer.sv
// Directed vector bench for tx_framer (IDLE_MIN=2 table, IDLE_MIN=1 sequence).
module tb_tx_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready,  s_ready1;
   logic [8:0] sym_out,  sym_out1;
   logic       underrun, underrun1;
   logic       busy,     busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_framer #(.IDLE_MIN(2)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .sym_out(sym_out),
      .underrun(underrun), .busy(busy)
   );

   tx_framer #(.IDLE_MIN(1)) dut1 (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready1), .sym_out(sym_out1),
      .underrun(underrun1), .busy(busy1)
   );

   typedef struct {
      logic       rst;
      logic       v;
      logic       l;
      logic [7:0] d;
      logic [8:0] sym;
      logic       rdy;
      logic       bsy;
      logic       und;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic l,
                      input logic [7:0] d, input logic [8:0] sym,
                      input logic rdy, input logic bsy, input logic und);
      vec_t x;
      x.rst = r; x.v = v; x.l = l; x.d = d;
      x.sym = sym; x.rdy = rdy; x.bsy = bsy; x.und = und;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
      end
   endtask

   initial begin
      logic [8:0] exp1 [0:10];
      int k;

      // reset then idle
      for (int i = 0; i < 10; i++)
         add(0, 0, 0, 8'h00, (i % 2) ? 9'h0C5 : 9'h1BC, 0, 0, 0);
      add(1, 0, 0, 8'h00, 9'h1BC, 0, 0, 0);
      // single frame 11 22 33, second frame pending at EOP
      add(0, 1, 0, 8'h11, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h1FB, 1, 1, 0);
      add(0, 1, 0, 8'h22, 9'h011, 1, 1, 0);
      add(0, 1, 1, 8'h33, 9'h022, 1, 1, 0);
      add(0, 1, 0, 8'h44, 9'h033, 0, 1, 0);
      add(0, 1, 0, 8'h44, 9'h1FD, 0, 1, 0);
      add(0, 1, 0, 8'h44, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h44, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h44, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h44, 9'h0C5, 0, 0, 0);
      // one-byte frame with K-looking payload
      add(0, 1, 1, 8'hBC, 9'h1FB, 1, 1, 0);
      add(0, 0, 0, 8'h00, 9'h0BC, 0, 1, 0);
      // underrun after first byte of a 4-byte frame
      add(0, 1, 0, 8'h11, 9'h1FD, 0, 1, 0);
      add(0, 1, 0, 8'h11, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h11, 9'h1FB, 1, 1, 0);
      add(0, 0, 0, 8'h00, 9'h011, 1, 1, 0);
      add(0, 1, 0, 8'h22, 9'h1FE, 1, 1, 1);
      add(0, 1, 0, 8'h33, 9'h1BC, 1, 0, 0);
      add(0, 1, 1, 8'h44, 9'h0C5, 1, 0, 0);
      add(0, 1, 1, 8'h55, 9'h1BC, 0, 0, 0);
      add(0, 1, 1, 8'h55, 9'h0C5, 0, 0, 0);
      add(0, 1, 1, 8'h55, 9'h1FB, 1, 1, 0);
      // next frame, then reset mid-DATA
      add(0, 1, 0, 8'h66, 9'h055, 0, 1, 0);
      add(0, 1, 0, 8'h66, 9'h1FD, 0, 1, 0);
      add(0, 1, 0, 8'h66, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h66, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h66, 9'h1BC, 0, 0, 0);
      add(0, 1, 0, 8'h66, 9'h0C5, 0, 0, 0);
      add(0, 1, 0, 8'h66, 9'h1FB, 1, 1, 0);
      add(1, 1, 0, 8'h77, 9'h066, 1, 1, 0);
      add(0, 0, 0, 8'h00, 9'h1BC, 0, 0, 0);
      add(0, 0, 0, 8'h00, 9'h0C5, 0, 0, 0);
      add(0, 0, 0, 8'h00, 9'h1BC, 0, 0, 0);

      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; s_valid = vecs[i].v;
         s_last = vecs[i].l; s_data = vecs[i].d;
         chk("sym_out",  i, sym_out, vecs[i].sym);
         chk("s_ready",  i, {8'd0, s_ready}, {8'd0, vecs[i].rdy});
         chk("busy",     i, {8'd0, busy}, {8'd0, vecs[i].bsy});
         chk("underrun", i, {8'd0, underrun}, {8'd0, vecs[i].und});
      end

      // IDLE_MIN=1: back-to-back one-byte frames separated by one pair
      exp1 = '{9'h1BC, 9'h0C5, 9'h1FB, 9'h0AA, 9'h1FD, 9'h1BC,
               9'h0C5, 9'h1FB, 9'h0BB, 9'h1FD, 9'h1BC};
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b0;
      k = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         rst = 1'b0;
         chk("min1_sym", i, sym_out1, exp1[i]);
         if (i == 2 || i == 7)
            chk("min1_busy", i, {8'd0, busy1}, 9'd1);
         s_valid = (k < 2);
         s_last = 1'b1;
         s_data = (k == 0) ? 8'hAA : 8'hBB;
         if (s_ready1 && s_valid) k++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_framer.md
# tx_framer

Transmit link-layer framer that sits directly upstream of the 8b/10b encoder. It converts a byte stream with valid/ready handshake and end-of-frame marking into a continuous 9-bit symbol stream, one symbol per clock. Each symbol is {k, byte}, with bit 8 as the control flag, matching the encoder's data input. The framer inserts idle ordered sets, start/end delimiters and an abort code on underrun.

## Interface
- `IDLE_MIN`, default 2: minimum number of complete idle pairs between frames, and after reset. Legal range 1..255.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 8: payload byte.
- `s_valid` in 1: `s_data`/`s_last` valid.
- `s_last` in 1: beat is the final byte of the frame.
- `s_ready` out 1: framer accepts a beat this cycle. Combinational from state only, with no dependency on `s_valid`.
- `sym_out` out 9: registered symbol, wired straight to the encoder's 9-bit data input.
- `underrun` out 1: registered one-cycle pulse when a frame is aborted.
- `busy` out 1: registered; high from SOP emission through EOP/abort emission.

## Operation
- Symbol constants, as {k, byte}:
  - K28.5 = 9'h1BC
  - D5.6 = 9'h0C5
  - K27.7 (SOP) = 9'h1FB
  - K29.7 (EOP) = 9'h1FD
  - K30.7 (abort) = 9'h1FE
  - Payload = {1'b0, s_data}.
- Idle ordered set: K28.5 followed by D5.6. Tracking state:
  - `phase` (0 means next idle symbol is K28.5).
  - `gap_cnt`, which saturates at `IDLE_MIN` and increments on every D5.6 emitted.
- States: IDLE, SOP, DATA, DROP, EOP.
- IDLE:
  - Emits idle symbols and toggles `phase`. `s_ready`=0.
  - Transitions to SOP on the edge that emits D5.6 when `s_valid`=1 and `gap_cnt`+1 >= `IDLE_MIN`.
  - A frame never starts mid-pair.
- SOP: emits K27.7, then DATA. `s_ready`=0.
- DATA: `s_ready`=1.
  - `s_valid`=1: emit payload. If `s_last`, go to EOP; otherwise stay in DATA.
  - `s_valid`=0: emit K30.7, pulse `underrun`, clear `gap_cnt` and `phase`, go to DROP.
- DROP:
  - `s_ready`=1; accepted beats are discarded. Emits idle pairs exactly as IDLE does, counting `gap_cnt`.
  - On an accepted beat with `s_last`=1, go to IDLE with `phase`/`gap_cnt` preserved.
- EOP: emits K29.7, clears `phase` and `gap_cnt`, then IDLE. `s_ready`=0.
- Frames never carry K symbols except the delimiters. Payload values 0xBC, 0xFB, etc. are sent with k=0 and need no escaping.
- A one-byte frame gives K27.7, byte, K29.7.

## Timing
- One symbol per cycle, always. There is no output stall.
- Latency: a beat accepted at edge N appears on `sym_out` after edge N, i.e. in cycle N+1.
- Reset values:
  - `sym_out`=9'h1BC, state IDLE, `phase`=1 (next symbol is D5.6).
  - `gap_cnt`=0, `underrun`=0, `busy`=0, `s_ready`=0.
- Minimum inter-frame spacing is EOP, then `IDLE_MIN` full pairs, then SOP.
- Reset asserted mid-frame: the frame is abandoned silently. No EOP or abort is sent; the stream resumes at the reset values the next cycle. Upstream flushes on `rst`.
- The underrun check takes priority over everything in DATA. `s_last` is ignored when `s_valid`=0.
- `gap_cnt` saturates and never wraps.

## Structure
- The shared package holds:
  - The five symbol constants (`SYM_K28_5`, `SYM_D5_6`, `SYM_SOP`, `SYM_EOP`, `SYM_ABORT`).
  - The state enum, so the RX deframer can reuse them.
- No sub-module. The encoder and its disparity register are instantiated alongside by the TX top, not inside this block.

## Test plan
- **Reset then idle:** hold `s_valid`=0 for 10 cycles. `sym_out` alternates 1BC, 0C5 starting 1BC; `s_ready`=0 throughout.
- **Single frame:** assert `s_valid` with bytes 0x11, 0x22, 0x33 (last on 0x33) as soon as allowed (`IDLE_MIN`=2).
  - Expect 1BC 0C5 1BC 0C5 1FB 011 022 033 1FD, then idles.
  - `busy` is high from 1FB through 1FD.
- **Back-to-back frames:** second frame pending at EOP. Exactly 2 idle pairs, then 1FB.
  - Also rerun with `IDLE_MIN`=1: exactly 1 pair.
- **Underrun:** drop `s_valid` after 0x11 in a 4-byte frame.
  - Expect 1FB 011 1FE, with a one-cycle `underrun` pulse, then idles starting 1BC.
  - Remaining beats are accepted and discarded until `s_last`; the next frame waits for 2 full pairs.
- **K-looking payload:** send byte 0xBC. `sym_out`=0BC (k=0), not 1BC.
- **Mid-frame reset:** assert `rst` during DATA. The next cycle shows reset values (`sym_out`=1BC, `busy`=0, `s_ready`=0), and no 1FD or 1FE is emitted.
